// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: width derivations, clog2 and the block accumulator FSM states.
package fp_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Integer bits of a format S(nb, nbf).
    function automatic int nbi(input int nb, input int nbf);
        return nb - nbf;
    endfunction

    // LSBs discarded when moving from nbf_in to nbf_out fractional bits.
    function automatic int round_drop(input int nbf_in, input int nbf_out);
        return (nbf_in > nbf_out) ? (nbf_in - nbf_out) : 0;
    endfunction

    // Default datapath formats shared by the adder and downstream stages.
    localparam int NB_IN_DEF   = 9;
    localparam int NBF_IN_DEF  = 8;
    localparam int NB_OUT_DEF  = 8;
    localparam int NBF_OUT_DEF = 6;
    localparam int NBI_IN_DEF  = NB_IN_DEF - NBF_IN_DEF;
    localparam int NBI_OUT_DEF = NB_OUT_DEF - NBF_OUT_DEF;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } acc_state_t;

endpackage

// File: rtl/fp_round_sat.sv
// Combinational round-half-up and saturate from S(NB_IN_RS,NBF_IN_RS) to S(NB_OUT,NBF_OUT).
module fp_round_sat
    import fp_pkg::*;
#(
    parameter int NB_IN_RS  = 12,
    parameter int NBF_IN_RS = 8,
    parameter int NB_OUT    = 8,
    parameter int NBF_OUT   = 6
) (
    input  logic [NB_IN_RS-1:0] data_in,
    output logic [NB_OUT-1:0]   data_out,
    output logic                sat
);

    localparam int DROP   = round_drop(NBF_IN_RS, NBF_OUT);
    localparam int NB_RND = (DROP > 0) ? (NB_IN_RS + 1 - DROP) : NB_IN_RS;

    logic [NB_RND-1:0] rnd;

    generate
        if (DROP > 0) begin : g_round
            localparam logic [NB_IN_RS:0] HALF = {{NB_IN_RS{1'b0}}, 1'b1} << (DROP - 1);
            logic [NB_IN_RS:0] ext;
            // One guard bit keeps the +half from wrapping at the positive limit.
            assign ext = {data_in[NB_IN_RS-1], data_in} + HALF;
            assign rnd = ext[NB_IN_RS:DROP];
        end else begin : g_no_round
            assign rnd = data_in;
        end
    endgenerate

    generate
        if (NB_RND > NB_OUT) begin : g_sat
            logic [NB_RND-NB_OUT:0] top;
            logic                   fits;
            assign top  = rnd[NB_RND-1:NB_OUT-1];
            assign fits = (&top) | ~(|top);
            assign sat  = ~fits;
            always_comb begin
                data_out = rnd[NB_OUT-1:0];
                if (!fits) begin
                    data_out = rnd[NB_RND-1] ? {1'b1, {(NB_OUT-1){1'b0}}}
                                             : {1'b0, {(NB_OUT-1){1'b1}}};
                end
            end
        end else if (NB_RND == NB_OUT) begin : g_exact
            assign sat      = 1'b0;
            assign data_out = rnd;
        end else begin : g_widen
            assign sat      = 1'b0;
            assign data_out = {{(NB_OUT-NB_RND){rnd[NB_RND-1]}}, rnd};
        end
    endgenerate

endmodule

// File: rtl/fp_block_acc.sv
// Block accumulator: sums 2^LOG2_N signed samples, then presents full-resolution and
// rounded/saturated results on a valid/ready output port.
module fp_block_acc
    import fp_pkg::*;
#(
    parameter int NB_IN   = 9,
    parameter int NBF_IN  = 8,
    parameter int LOG2_N  = 3,
    parameter int NB_OUT  = 8,
    parameter int NBF_OUT = 6
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_IN-1:0]        i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [NB_IN+LOG2_N-1:0] o_acc_fr,
    output logic [NB_OUT-1:0]       o_acc_rs,
    output logic                    o_sat,
    output logic                    o_valid,
    input  logic                    i_ready
);

    localparam int NB_ACC  = NB_IN + LOG2_N;
    localparam int NBF_ACC = NBF_IN;

    acc_state_t          state, state_next;
    logic [NB_ACC-1:0]   acc, acc_next;
    logic [LOG2_N-1:0]   cnt, cnt_next;
    logic [NB_ACC-1:0]   sum;
    logic [NB_OUT-1:0]   rs_value;
    logic                rs_sat;
    logic                accept;
    logic                load;

    assign sum     = acc + {{LOG2_N{i_data[NB_IN-1]}}, i_data};
    assign o_ready = (state == ST_ACC);
    assign o_valid = (state == ST_DONE);
    assign accept  = i_valid & o_ready;

    fp_round_sat #(
        .NB_IN_RS  (NB_ACC),
        .NBF_IN_RS (NBF_ACC),
        .NB_OUT    (NB_OUT),
        .NBF_OUT   (NBF_OUT)
    ) u_round_sat (
        .data_in  (sum),
        .data_out (rs_value),
        .sat      (rs_sat)
    );

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        load       = 1'b0;
        unique case (state)
            ST_ACC: begin
                if (accept) begin
                    if (&cnt) begin
                        // Last sample of the block goes straight into the result.
                        acc_next   = '0;
                        cnt_next   = '0;
                        load       = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        acc_next = sum;
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_ACC;
            acc      <= '0;
            cnt      <= '0;
            o_acc_fr <= '0;
            o_acc_rs <= '0;
            o_sat    <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            if (load) begin
                o_acc_fr <= sum;
                o_acc_rs <= rs_value;
                o_sat    <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_fp_block_acc.sv
// Self-checking bench for fp_block_acc: transaction-level model plus directed literal blocks.
module tb_fp_block_acc;

    logic        clk;
    logic        rst;
    logic [8:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [11:0] o_acc_fr;
    logic [7:0]  o_acc_rs;
    logic        o_sat;
    logic        o_valid;
    logic        i_ready;

    int checks;
    int failures;

    fp_block_acc dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_acc_fr (o_acc_fr),
        .o_acc_rs (o_acc_rs),
        .o_sat    (o_sat),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, round half up to 1/64, clamp to S(8,6).
    task automatic model_result(input int s, output logic [11:0] fr, output logic [7:0] rs,
                                output logic sat);
        int r;
        fr = s[11:0];
        r  = (s + 2) >>> 2;
        if (r > 127) begin
            rs = 8'h7F; sat = 1'b1;
        end else if (r < -128) begin
            rs = 8'h80; sat = 1'b1;
        end else begin
            rs = r[7:0]; sat = 1'b0;
        end
    endtask

    // Model state
    bit          mon_en;
    int          m_sum;
    int          m_cnt;
    bit          m_busy;
    logic [11:0] e_fr;
    logic [7:0]  e_rs;
    logic        e_sat;
    int          got_n;
    logic [11:0] got_fr;
    logic [7:0]  got_rs;
    logic        got_sat;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_valid", {31'd0, o_valid}, {31'd0, m_busy});
            chk("o_ready", {31'd0, o_ready}, {31'd0, !m_busy});
            if (m_busy) begin
                chk("o_acc_fr", {20'd0, o_acc_fr}, {20'd0, e_fr});
                chk("o_acc_rs", {24'd0, o_acc_rs}, {24'd0, e_rs});
                chk("o_sat", {31'd0, o_sat}, {31'd0, e_sat});
            end
            if (o_valid && i_ready && !rst) begin
                got_fr  = o_acc_fr;
                got_rs  = o_acc_rs;
                got_sat = o_sat;
                got_n++;
            end
            if (rst) begin
                m_sum = 0; m_cnt = 0; m_busy = 0;
            end else if (m_busy) begin
                if (i_ready) m_busy = 0;
            end else if (i_valid) begin
                m_sum += int'($signed(i_data));
                m_cnt++;
                if (m_cnt == 8) begin
                    model_result(m_sum, e_fr, e_rs, e_sat);
                    m_busy = 1; m_sum = 0; m_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [8:0] d);
        int n;
        n = 0;
        i_data  = d;
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_const(input logic [8:0] first, input logic [8:0] rest);
        send(first);
        for (int i = 0; i < 7; i++) send(rest);
    endtask

    task automatic wait_result(input int prev);
        int n;
        n = 0;
        while (got_n == prev && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (got_n == prev) chk("result_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic directed(input string name, input logic [8:0] first, input logic [8:0] rest,
                            input logic [11:0] fr, input logic [7:0] rs, input logic sat);
        int prev;
        prev = got_n;
        run_const(first, rest);
        wait_result(prev);
        chk({name, "_fr"}, {20'd0, got_fr}, {20'd0, fr});
        chk({name, "_rs"}, {24'd0, got_rs}, {24'd0, rs});
        chk({name, "_sat"}, {31'd0, got_sat}, {31'd0, sat});
    endtask

    initial begin
        int prev;
        checks = 0; failures = 0; got_n = 0;
        mon_en = 0; m_sum = 0; m_cnt = 0; m_busy = 0;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_fr", {20'd0, o_acc_fr}, 32'd0);
        chk("rst_rs", {24'd0, o_acc_rs}, 32'd0);
        chk("rst_sat", {31'd0, o_sat}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1;

        directed("unity",   9'h020, 9'h020, 12'h100, 8'h40, 1'b0);
        directed("pos_sat", 9'h0FF, 9'h0FF, 12'h7F8, 8'h7F, 1'b1);
        directed("neg_sat", 9'h100, 9'h100, 12'h800, 8'h80, 1'b1);
        directed("tie_pos", 9'h002, 9'h000, 12'h002, 8'h01, 1'b0);
        directed("tie_neg", 9'h1FE, 9'h000, 12'hFFE, 8'h00, 1'b0);

        // Backpressure: hold the result while upstream keeps offering samples.
        i_ready = 1'b0;
        prev = got_n;
        run_const(9'h010, 9'h010);
        for (int i = 0; i < 5; i++) begin
            i_valid = ~i_valid;
            i_data  = 9'($urandom);
            @(negedge clk);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
            chk("bp_fr", {20'd0, o_acc_fr}, 32'h080);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_transfer", got_n, prev + 1);
        directed("after_bp", 9'h020, 9'h020, 12'h100, 8'h40, 1'b0);

        // Reset mid-block discards the partial sum and the old result.
        for (int i = 0; i < 3; i++) send(9'h0FF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_fr", {20'd0, o_acc_fr}, 32'd0);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        directed("after_rst", 9'h020, 9'h020, 12'h100, 8'h40, 1'b0);

        // Random traffic; the monitor model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            i_valid = ($urandom % 3) != 0;
            i_data  = 9'($urandom);
            i_ready = ($urandom % 4) != 0;
            rst     = ($urandom % 400) == 0;
            @(posedge clk); #1;
        end
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("random_blocks_seen", {31'd0, got_n > 50}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
